// File: rtl/fl_demux_pkg.sv
// Shared types for the Frame Link demultiplexer: FSM states, delimiter bundle and
// the select-width helper.
package fl_demux_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StDiscard
  } state_e;

  typedef struct packed {
    logic sof_n;
    logic eof_n;
    logic sop_n;
    logic eop_n;
  } fl_delim_t;

  function automatic int unsigned sel_width(input int unsigned channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fl_demux_skid.sv
// Two-entry skid buffer (main + skid register) with a registered ready so the
// downstream ready never reaches the upstream ready combinationally.
module fl_demux_skid #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q;
  logic             accept;

  assign accept      = in_valid_i & rdy_q;
  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_ready_i) begin
      // Main frees up: refill from skid first, otherwise straight from the input.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = in_data_i;
      end
    end else if (accept) begin
      skid_d     = in_data_i;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

endmodule

// File: rtl/fl_demultiplexer.sv
// Frame Link demultiplexer: steers whole frames to one of CHANNELS outputs using the
// select latched at SOF; frames with an out-of-range select are consumed and counted.
module fl_demultiplexer
  import fl_demux_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DREM_WIDTH = $clog2(DATA_WIDTH / 8),
  parameter int unsigned SEL_WIDTH  = sel_width(CHANNELS),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic [SEL_WIDTH-1:0]           RX_SEL,
  input  logic [DATA_WIDTH-1:0]          RX_DATA,
  input  logic [DREM_WIDTH-1:0]          RX_REM,
  input  logic                           RX_SOF_N,
  input  logic                           RX_EOF_N,
  input  logic                           RX_SOP_N,
  input  logic                           RX_EOP_N,
  input  logic                           RX_SRC_RDY_N,
  output logic                           RX_DST_RDY_N,
  output logic [CHANNELS*DATA_WIDTH-1:0] TX_DATA,
  output logic [CHANNELS*DREM_WIDTH-1:0] TX_REM,
  output logic [CHANNELS-1:0]            TX_SOF_N,
  output logic [CHANNELS-1:0]            TX_EOF_N,
  output logic [CHANNELS-1:0]            TX_SOP_N,
  output logic [CHANNELS-1:0]            TX_EOP_N,
  output logic [CHANNELS-1:0]            TX_SRC_RDY_N,
  input  logic [CHANNELS-1:0]            TX_DST_RDY_N,
  output logic [CNT_WIDTH-1:0]           DROP_CNT
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DREM_WIDTH-1:0] rem;
    fl_delim_t             delim;
    logic [SEL_WIDTH-1:0]  chan;
  } entry_t;

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] chan_q, chan_d, fwd_chan;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 rx_acc, sel_ok, fwd, drop_inc;
  logic                 buf_ready, out_valid, out_ready;
  entry_t               in_entry, out_entry;
  logic [CHANNELS-1:0]  sel_hit;

  assign RX_DST_RDY_N = ~buf_ready;
  assign rx_acc       = ~RX_SRC_RDY_N & buf_ready;
  assign sel_ok       = 32'(RX_SEL) < CHANNELS;
  assign DROP_CNT     = drop_cnt_q;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    fwd_chan = chan_q;
    fwd      = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Non-SOF words here are orphans and vanish without being counted.
        if (rx_acc && !RX_SOF_N) begin
          if (sel_ok) begin
            fwd      = 1'b1;
            fwd_chan = RX_SEL;
            chan_d   = RX_SEL;
            if (RX_EOF_N) state_d = StFrame;
          end else begin
            drop_inc = 1'b1;
            if (RX_EOF_N) state_d = StDiscard;
          end
        end
      end
      StFrame: begin
        if (rx_acc) begin
          fwd = 1'b1;
          if (!RX_EOF_N) state_d = StIdle;
        end
      end
      StDiscard: begin
        if (rx_acc && !RX_EOF_N) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    drop_cnt_d = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      chan_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign in_entry = '{
    data:  RX_DATA,
    rem:   RX_REM,
    delim: '{sof_n: RX_SOF_N, eof_n: RX_EOF_N, sop_n: RX_SOP_N, eop_n: RX_EOP_N},
    chan:  fwd_chan
  };

  fl_demux_skid #(
    .Width($bits(entry_t))
  ) u_skid (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .in_valid_i (fwd),
    .in_data_i  (in_entry),
    .in_ready_o (buf_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_entry),
    .out_ready_i(out_ready)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_tx
    assign sel_hit[c] = out_valid && (out_entry.chan == SEL_WIDTH'(c));
    assign TX_DATA[c*DATA_WIDTH +: DATA_WIDTH] = out_entry.data;
    assign TX_REM[c*DREM_WIDTH +: DREM_WIDTH]  = out_entry.rem;
    assign TX_SOF_N[c]     = ~sel_hit[c] | out_entry.delim.sof_n;
    assign TX_EOF_N[c]     = ~sel_hit[c] | out_entry.delim.eof_n;
    assign TX_SOP_N[c]     = ~sel_hit[c] | out_entry.delim.sop_n;
    assign TX_EOP_N[c]     = ~sel_hit[c] | out_entry.delim.eop_n;
    assign TX_SRC_RDY_N[c] = ~sel_hit[c];
  end

  assign out_ready = |(sel_hit & ~TX_DST_RDY_N);

endmodule
